axistream_forwarder: RTL and testbench

// - Egress counterpart of the AXI-Stream snooper: reads one finished packet out of a packet buffer and transmits it as an AXI-Stream master.
// - Sits between parallel_cores' forwarder port (read side of the ping-pong packet memories) and the downstream AXI-Stream sink.
// - Honours TREADY backpressure without losing in-flight memory reads, using a small skid FIFO.

---
 rtl/axistream_pkg.sv | 31 +++
 rtl/fwd_skid_fifo.sv | 59 +++++
 rtl/axistream_forwarder.sv | 154 +++++++++++++++
 tb/tb_axistream_forwarder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axistream_pkg.sv
// Shared state encoding and helpers for the AXI-Stream snooper and forwarder.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package axistream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fwd_state_t;

    // Widest keep vector the helpers produce; callers cast down to their lane count.
    localparam int KEEP_MAX = 128;

    function automatic logic [63:0] ceil_div(input logic [63:0] num, input logic [63:0] den);
        return (num / den) + {63'd0, (num % den) != 64'd0};
    endfunction

    // Low 'rem' lanes set; a zero remainder means the final word is full.
    function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned rem, input int unsigned lanes);
        logic [KEEP_MAX-1:0] m;
        int unsigned         n;
        n = (rem == 0) ? lanes : rem;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/fwd_skid_fifo.sv
// Small synchronous FIFO holding in-flight packet-memory read beats.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full unless a pop frees a slot the same cycle.
module fwd_skid_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/axistream_forwarder.sv
// Reads one finished packet from the packet buffer and sends it as an AXI-Stream master.
// Latency: first TVALID 2+PESS cycles after the ack, then one beat per cycle.
// Backpressure: reads issue only when the skid FIFO can absorb every in-flight word.
module axistream_forwarder
    import axistream_pkg::*;
#(
    parameter int  FWD_DATA_WIDTH = 64,
    parameter int  FWD_ADDR_WIDTH = 9,
    parameter int  PLEN_WIDTH     = 32,
    parameter int  PESS           = 0,
    localparam int KEEP_WIDTH     = FWD_DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [FWD_ADDR_WIDTH-1:0] fwd_addr,
    output logic                      fwd_rd_en,
    input  logic [FWD_DATA_WIDTH-1:0] fwd_rd_data,
    input  logic [PLEN_WIDTH-1:0]     fwd_byte_len,
    input  logic                      rdy_for_fwd,
    output logic                      rdy_for_fwd_ack,
    output logic                      fwd_done,
    output logic [FWD_DATA_WIDTH-1:0] fwd_TDATA,
    output logic [KEEP_WIDTH-1:0]     fwd_TKEEP,
    output logic                      fwd_TVALID,
    output logic                      fwd_TLAST,
    input  logic                      fwd_TREADY
);

    localparam int PIPE  = 1 + PESS;
    localparam int DEPTH = 2 + PESS + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int NW_W  = FWD_ADDR_WIDTH + 1;
    localparam logic [NW_W-1:0] MAX_WORDS = {1'b1, {FWD_ADDR_WIDTH{1'b0}}};

    typedef struct packed {
        logic [FWD_DATA_WIDTH-1:0] dat;
        logic [KEEP_WIDTH-1:0]     keep;
        logic                      last;
    } beat_t;

    fwd_state_t            state, state_nxt;
    logic [NW_W-1:0]       rd_cnt;
    logic [NW_W-1:0]       nwords;
    logic [KEEP_WIDTH-1:0] last_keep;
    logic [PIPE-1:0]       vld_sr;
    logic [PIPE-1:0]       last_sr;
    logic                  ack_q;
    logic                  done_q;

    logic [63:0]           len64;
    logic [63:0]           nw64;
    logic                  sat;
    logic [NW_W-1:0]       nw_sat;
    logic [KEEP_WIDTH-1:0] keep_nxt;
    logic                  accept;
    logic                  is_last_rd;
    logic                  rd_issue;
    logic [CW-1:0]         in_flight;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    beat_t                 push_beat;
    beat_t                 head_beat;

    always_comb begin
        len64    = 64'(fwd_byte_len);
        nw64     = ceil_div(len64, 64'(KEEP_WIDTH));
        sat      = nw64 > 64'(MAX_WORDS);
        nw_sat   = sat ? MAX_WORDS : NW_W'(nw64);
        // A truncated packet ends on a full word, so its last beat keeps every lane.
        keep_nxt = KEEP_WIDTH'(keep_mask(sat ? 32'd0 : 32'(len64 % 64'(KEEP_WIDTH)),
                                         32'(KEEP_WIDTH)));
    end

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < PIPE; i++) begin
            in_flight = in_flight + CW'(vld_sr[i]);
        end
    end

    assign accept     = (state == ST_IDLE) && rdy_for_fwd;
    assign is_last_rd = (rd_cnt == nwords - NW_W'(1));
    assign rd_issue   = (state == ST_READ) && ((CW'(DEPTH) - fifo_count) > in_flight);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (rdy_for_fwd) state_nxt = (nw_sat == '0) ? ST_DONE : ST_READ;
            ST_READ:  if (rd_issue && is_last_rd) state_nxt = ST_DRAIN;
            ST_DRAIN: if (fifo_empty && (vld_sr == '0)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_cnt    <= '0;
            nwords    <= '0;
            last_keep <= '0;
            vld_sr    <= '0;
            last_sr   <= '0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            ack_q  <= accept;
            done_q <= (state == ST_DONE);
            if (accept) begin
                nwords    <= nw_sat;
                last_keep <= keep_nxt;
                rd_cnt    <= '0;
            end else if (rd_issue) begin
                rd_cnt <= rd_cnt + NW_W'(1);
            end
            // Tags ride alongside each read until its data returns from memory.
            vld_sr[0]  <= rd_issue;
            last_sr[0] <= rd_issue && is_last_rd;
            for (int i = 1; i < PIPE; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    assign push_beat.dat  = fwd_rd_data;
    assign push_beat.keep = last_sr[PIPE-1] ? last_keep : {KEEP_WIDTH{1'b1}};
    assign push_beat.last = last_sr[PIPE-1];

    fwd_skid_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (DEPTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (vld_sr[PIPE-1]),
        .push_dat (push_beat),
        .pop      (fwd_TVALID && fwd_TREADY),
        .head_dat (head_beat),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign fwd_addr        = rd_cnt[FWD_ADDR_WIDTH-1:0];
    assign fwd_rd_en       = rd_issue;
    assign rdy_for_fwd_ack = ack_q;
    assign fwd_done        = done_q;
    assign fwd_TVALID      = !fifo_empty;
    assign fwd_TDATA       = fifo_empty ? '0 : head_beat.dat;
    assign fwd_TKEEP       = fifo_empty ? '0 : head_beat.keep;
    assign fwd_TLAST       = !fifo_empty && head_beat.last;

endmodule

// File: tb/tb_axistream_forwarder.sv
// Scoreboard bench: two forwarders (1- and 2-cycle memory latency) with behavioural memories.
module tb_axistream_forwarder;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic [8:0]  addr      [2];
    logic        rd_en     [2];
    logic [63:0] rd_data   [2];
    logic [31:0] blen      [2];
    logic        rdy       [2];
    logic        ack       [2];
    logic        done      [2];
    logic [63:0] tdata     [2];
    logic [7:0]  tkeep     [2];
    logic        tvalid    [2];
    logic        tlast     [2];
    logic        tready    [2];

    exp_t        exp_q     [2][$];
    int          ack_cnt   [2] = '{0, 0};
    int          done_cnt  [2] = '{0, 0};
    int          rd_cnt    [2] = '{0, 0};
    int          beat_cnt  [2] = '{0, 0};
    int          vld_cnt   [2] = '{0, 0};
    int          ack_cyc   [2] = '{0, 0};
    int          done_cyc  [2] = '{0, 0};
    int          first_vld [2] = '{-1, -1};
    int          last_pop  [2] = '{0, 0};
    int          rd_exp    [2] = '{0, 0};
    bit          mode      [2] = '{0, 0};
    logic [15:0] tag = 16'd0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [63:0] mk_word(input int a, input logic [15:0] t);
        logic [15:0] a16;
        a16 = a[15:0];
        return {t, 16'hC0DE, ~a16, a16};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [63:0] m1, m2;

        axistream_forwarder #(.PESS(g)) u_dut (
            .clk             (clk),
            .rst             (rst[g]),
            .fwd_addr        (addr[g]),
            .fwd_rd_en       (rd_en[g]),
            .fwd_rd_data     (rd_data[g]),
            .fwd_byte_len    (blen[g]),
            .rdy_for_fwd     (rdy[g]),
            .rdy_for_fwd_ack (ack[g]),
            .fwd_done        (done[g]),
            .fwd_TDATA       (tdata[g]),
            .fwd_TKEEP       (tkeep[g]),
            .fwd_TVALID      (tvalid[g]),
            .fwd_TLAST       (tlast[g]),
            .fwd_TREADY      (tready[g])
        );

        // Memory returns garbage unless a read was strobed, exposing latency slips.
        always @(posedge clk) begin
            m1 <= rd_en[g] ? mk_word(int'(addr[g]), tag) : 64'hDEAD_BEEF_DEAD_BEEF;
            m2 <= m1;
        end
        assign rd_data[g] = (g == 0) ? m1 : m2;

        always @(negedge clk) begin : mon
            exp_t e;
            if (rst[g]) begin
                exp_q[g].delete();
            end else begin
                if (ack[g]) begin
                    ack_cnt[g]++;
                    ack_cyc[g]   = cyc;
                    rd_exp[g]    = 0;
                    first_vld[g] = -1;
                end
                if (done[g]) begin
                    done_cnt[g]++;
                    done_cyc[g] = cyc;
                end
                if (rd_en[g]) begin
                    check($sformatf("rd_addr dut%0d", g), 64'(addr[g]), 64'(rd_exp[g]));
                    rd_exp[g]++;
                    rd_cnt[g]++;
                end
                if (tvalid[g]) begin
                    vld_cnt[g]++;
                    if (first_vld[g] < 0) first_vld[g] = cyc;
                    if (exp_q[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat dut%0d: got data %0h, no beat expected", g, tdata[g]);
                    end else begin
                        e = exp_q[g][0];
                        check($sformatf("tdata dut%0d", g), tdata[g], e.d);
                        check($sformatf("tkeep dut%0d", g), 64'(tkeep[g]), 64'(e.k));
                        check($sformatf("tlast dut%0d", g), 64'(tlast[g]), 64'(e.l));
                        if (tready[g]) begin
                            void'(exp_q[g].pop_front());
                            beat_cnt[g]++;
                            last_pop[g] = cyc;
                        end
                    end
                end
            end
        end
    end

    // TREADY is either held high or follows the repeating 1,0,0 stall pattern.
    initial forever begin
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) tready[g] = mode[g] ? ((cyc % 3) == 0) : 1'b1;
    end

    task automatic push_expected(input int g, input int nbeats, input logic [7:0] last_keep);
        exp_t e;
        for (int i = 0; i < nbeats; i++) begin
            e.d = mk_word(i, tag);
            e.l = (i == nbeats - 1);
            e.k = e.l ? last_keep : 8'hFF;
            exp_q[g].push_back(e);
        end
    endtask

    task automatic claim(input int g, input int len);
        int a0;
        a0 = ack_cnt[g];
        @(posedge clk);
        #1;
        rdy[g]  = 1'b1;
        blen[g] = 32'(len);
        for (int c = 0; c < 20 && ack_cnt[g] == a0; c++) begin
            @(posedge clk);
            #1;
        end
        rdy[g] = 1'b0;
    endtask

    task automatic send_pkt(input int g, input int len, input int nbeats,
                            input logic [7:0] last_keep, input bit thru);
        int a0, d0, r0, b0, v0;
        tag = tag + 16'd1;
        a0 = ack_cnt[g]; d0 = done_cnt[g]; r0 = rd_cnt[g]; b0 = beat_cnt[g]; v0 = vld_cnt[g];
        push_expected(g, nbeats, last_keep);
        claim(g, len);
        for (int c = 0; c < 3000 && done_cnt[g] == d0; c++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("ack_count len%0d", len), 64'(ack_cnt[g] - a0), 64'd1);
        check($sformatf("done_count len%0d", len), 64'(done_cnt[g] - d0), 64'd1);
        check($sformatf("read_count len%0d", len), 64'(rd_cnt[g] - r0), 64'(nbeats));
        check($sformatf("beat_count len%0d", len), 64'(beat_cnt[g] - b0), 64'(nbeats));
        check($sformatf("done_after_ack len%0d", len), 64'(done_cyc[g] > ack_cyc[g]), 64'd1);
        check($sformatf("queue_drained len%0d", len), 64'(exp_q[g].size()), 64'd0);
        if (nbeats == 0) begin
            check("valid_cycles len0", 64'(vld_cnt[g] - v0), 64'd0);
        end else begin
            check($sformatf("first_valid_latency len%0d", len),
                  64'(first_vld[g] - ack_cyc[g]), 64'(2 + g));
        end
        if (thru) begin
            check($sformatf("throughput len%0d", len),
                  64'(last_pop[g] - first_vld[g]), 64'(nbeats - 1));
        end
    endtask

    initial begin
        int b0, d0;
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; rdy[g] = 1'b0; blen[g] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst fwd_addr dut%0d", g), 64'(addr[g]), 64'd0);
            check($sformatf("rst fwd_rd_en dut%0d", g), 64'(rd_en[g]), 64'd0);
            check($sformatf("rst ack dut%0d", g), 64'(ack[g]), 64'd0);
            check($sformatf("rst fwd_done dut%0d", g), 64'(done[g]), 64'd0);
            check($sformatf("rst TVALID dut%0d", g), 64'(tvalid[g]), 64'd0);
            check($sformatf("rst TLAST dut%0d", g), 64'(tlast[g]), 64'd0);
            check($sformatf("rst TKEEP dut%0d", g), 64'(tkeep[g]), 64'd0);
            check($sformatf("rst TDATA dut%0d", g), tdata[g], 64'd0);
        end
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        send_pkt(0, 24, 3, 8'hFF, 1'b1);
        send_pkt(0, 13, 2, 8'h1F, 1'b1);
        mode[0] = 1'b1;
        send_pkt(0, 64, 8, 8'hFF, 1'b0);
        mode[0] = 1'b0;
        send_pkt(0, 0, 0, 8'h00, 1'b0);
        send_pkt(0, 5000, 512, 8'hFF, 1'b1);
        mode[1] = 1'b1;
        send_pkt(1, 64, 8, 8'hFF, 1'b0);
        mode[1] = 1'b0;
        send_pkt(1, 24, 3, 8'hFF, 1'b1);

        // Reset lands while beat 3 of an 8-beat packet is on the bus.
        tag = tag + 16'd1;
        b0 = beat_cnt[0];
        d0 = done_cnt[0];
        push_expected(0, 8, 8'hFF);
        claim(0, 64);
        for (int c = 0; c < 100 && (beat_cnt[0] - b0) < 2; c++) begin
            @(posedge clk);
            #1;
        end
        check("beats_before_rst", 64'(beat_cnt[0] - b0), 64'd2);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        check("tvalid_after_rst", 64'(tvalid[0]), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check("no_done_after_rst", 64'(done_cnt[0] - d0), 64'd0);
        check("queue_flushed_by_rst", 64'(exp_q[0].size()), 64'd0);
        send_pkt(0, 16, 2, 8'hFF, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
